// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline write-back and a late-result FIFO
// Ports: clk/rst (sync, active-high); pipe_wb_* in, pipe_stall out (comb);
//        late_* in, late_ready out (comb); rf_we/rf_waddr/rf_wdata and late_pending out (registered)
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_rd,
  input  logic [31:0] pipe_wb_data,
  output logic        pipe_stall,
  input  logic        late_valid,
  input  logic [4:0]  late_rd,
  input  logic [31:0] late_data,
  output logic        late_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] late_pending
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]       q_rd   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wp, rp;
  logic [SW-1:0]    starve;
  logic             empty, fifo_gnt, pipe_gnt, gnt, push;
  logic [4:0]       g_rd;
  logic [31:0]      g_data, pend_n;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // per-slot valid bits make full/empty direct reductions
  assign empty      = ~|vld;
  assign late_ready = ~&vld;
  assign fifo_gnt   = !empty && (starve == SW'(STARVE_LIMIT) || !pipe_wb_valid);
  assign pipe_gnt   = pipe_wb_valid && !fifo_gnt;
  assign pipe_stall = pipe_wb_valid && fifo_gnt;
  assign gnt        = fifo_gnt || pipe_gnt;
  assign push       = late_valid && late_ready;
  assign g_rd       = fifo_gnt ? q_rd[rp] : pipe_wb_rd;
  assign g_data     = fifo_gnt ? q_data[rp] : pipe_wb_data;
  // a push never lands on a live slot, so push and pop-of-head are independent per slot
  always_comb begin
    pend_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (push && wp == PW'(i)) pend_n[late_rd] = 1'b1;
      else if (vld[i] && !(fifo_gnt && rp == PW'(i))) pend_n[q_rd[i]] = 1'b1;
    end
    pend_n[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wp]   <= late_rd;
      q_data[wp] <= late_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld          <= '0;
      wp           <= '0;
      rp           <= '0;
      starve       <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      late_pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        vld[i] <= (push && wp == PW'(i)) ? 1'b1 : (fifo_gnt && rp == PW'(i)) ? 1'b0 : vld[i];
      wp           <= push ? nxt(wp) : wp;
      rp           <= fifo_gnt ? nxt(rp) : rp;
      starve       <= (empty || fifo_gnt) ? '0 : starve == SW'(STARVE_LIMIT) ? starve : starve + 1'b1;
      rf_we        <= gnt && g_rd != 5'd0;
      rf_waddr     <= gnt ? g_rd : rf_waddr;
      rf_wdata     <= gnt ? g_data : rf_wdata;
      late_pending <= pend_n;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized checks of wb_port_arbiter against a queue-based model
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;
  logic        clk = 0, rst = 1;
  logic        pipe_wb_valid = 0, late_valid = 0;
  logic [4:0]  pipe_wb_rd = 0, late_rd = 0;
  logic [31:0] pipe_wb_data = 0, late_data = 0;
  logic        pipe_stall, late_ready, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, late_pending;
  int total = 0, bad = 0;
  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_stall(pipe_stall),
    .late_valid(late_valid), .late_rd(late_rd), .late_data(late_data), .late_ready(late_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .late_pending(late_pending)
  );
  always #5 clk = ~clk;
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  int          m_lost = 0;
  logic        m_we = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_data = 0, m_pend = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: the queue is the FIFO; m_lost counts slots the head has lost to the pipe
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_lost = 0; m_we = 0; m_addr = 0; m_data = 0; m_pend = 0;
    end else begin
      ent_t e;
      bit take_fifo, had, acc;
      had       = mq.size() > 0;
      take_fifo = had && (m_lost >= LIM || !pipe_wb_valid);
      acc       = late_valid && mq.size() < DEPTH;
      if (take_fifo) begin
        e = mq.pop_front();
        m_we = e.rd != 0; m_addr = e.rd; m_data = e.data;
        m_lost = 0;
      end else begin
        m_we = pipe_wb_valid && pipe_wb_rd != 0;
        if (pipe_wb_valid) begin m_addr = pipe_wb_rd; m_data = pipe_wb_data; end
        m_lost = had ? (m_lost < LIM ? m_lost + 1 : LIM) : 0;
      end
      if (acc) begin e.rd = late_rd; e.data = late_data; mq.push_back(e); end
      m_pend = 0;
      foreach (mq[i]) if (mq[i].rd != 0) m_pend[mq[i].rd] = 1'b1;
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("rf_we", 32'(rf_we), 32'(m_we));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
      chk("rf_wdata", rf_wdata, m_data);
      chk("late_pending", late_pending, m_pend);
      chk("pipe_stall", 32'(pipe_stall), 32'(pipe_wb_valid && mq.size() > 0 && m_lost >= LIM));
      chk("late_ready", 32'(late_ready), 32'(mq.size() < DEPTH));
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_wb_valid = v; pipe_wb_rd = rd; pipe_wb_data = d;
  endtask
  task automatic late(input logic v, input logic [4:0] rd, input logic [31:0] d);
    late_valid = v; late_rd = rd; late_data = d;
  endtask
  initial begin
    step(); step();
    rst = 0;
    chk("reset_we", 32'(rf_we), 0);
    chk("reset_waddr", 32'(rf_waddr), 0);
    chk("reset_wdata", rf_wdata, 0);
    chk("reset_pend", late_pending, 0);
    chk("reset_ready", 32'(late_ready), 1);
    // pipe only
    pipe(1, 5, 32'h1234);
    chk("t1_stall", 32'(pipe_stall), 0);
    step(); pipe(0, 0, 0);
    chk("t1_we", 32'(rf_we), 1);
    chk("t1_waddr", 32'(rf_waddr), 5);
    chk("t1_wdata", rf_wdata, 32'h1234);
    step();
    // late into idle
    late(1, 7, 32'hAA);
    chk("t2_ready", 32'(late_ready), 1);
    step(); late(0, 0, 0);
    chk("t2_pend", late_pending, 32'h80);
    chk("t2_we0", 32'(rf_we), 0);
    step();
    chk("t2_we", 32'(rf_we), 1);
    chk("t2_waddr", 32'(rf_waddr), 7);
    chk("t2_wdata", rf_wdata, 32'hAA);
    chk("t2_pend0", late_pending, 0);
    step();
    // starvation
    pipe(1, 3, 32'h33); late(1, 9, 32'h99);
    step(); late(0, 0, 0);
    for (int k = 0; k < LIM; k++) begin
      chk("t3_nostall", 32'(pipe_stall), 0);
      step();
    end
    chk("t3_stall", 32'(pipe_stall), 1);
    step();
    chk("t3_late_we", 32'(rf_we), 1);
    chk("t3_late_addr", 32'(rf_waddr), 9);
    chk("t3_late_data", rf_wdata, 32'h99);
    chk("t3_regrant", 32'(pipe_stall), 0);
    step(); pipe(0, 0, 0);
    chk("t3_pipe_addr", 32'(rf_waddr), 3);
    step();
    // full FIFO, held third push, drain order
    pipe(1, 2, 32'h22); late(1, 10, 32'hA0);
    step(); late(1, 11, 32'hB0);
    step(); late(1, 12, 32'hC0);
    chk("t4_full", 32'(late_ready), 0);
    step(); step(); step();
    chk("t4_full_pop", 32'(late_ready), 0);
    chk("t4_stall", 32'(pipe_stall), 1);
    step();
    chk("t4_ready", 32'(late_ready), 1);
    chk("t4_first", 32'(rf_waddr), 10);
    step(); late(0, 0, 0); pipe(0, 0, 0);
    chk("t4_pipe", 32'(rf_waddr), 2);
    step();
    chk("t4_second", 32'(rf_waddr), 11);
    step();
    chk("t4_third", 32'(rf_waddr), 12);
    chk("t4_third_data", rf_wdata, 32'hC0);
    step();
    chk("t4_pend0", late_pending, 0);
    // r0 writes
    pipe(1, 0, 32'h55);
    step(); pipe(0, 0, 0);
    chk("t5_pipe_r0", 32'(rf_we), 0);
    late(1, 0, 32'h66);
    chk("t5_ready", 32'(late_ready), 1);
    step(); late(0, 0, 0);
    chk("t5_pend", late_pending, 0);
    step();
    chk("t5_late_r0", 32'(rf_we), 0);
    chk("t5_popped", 32'(late_ready), 1);
    step();
    // reset mid-operation
    pipe(1, 4, 32'h44); late(1, 20, 32'h200);
    step(); late(1, 21, 32'h210);
    step(); late(0, 0, 0); rst = 1;
    step(); rst = 0; pipe(0, 0, 0);
    chk("t6_we", 32'(rf_we), 0);
    chk("t6_ready", 32'(late_ready), 1);
    chk("t6_pend", late_pending, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_ghost", 32'(rf_we), 0);
    end
    // randomized traffic in phases of differing pipe pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 1000; n++) begin
        pipe($urandom_range(0, 3) < ph + 1 ? 1'b1 : 1'b0,
             $urandom_range(0, 5) == 0 ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
        late($urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
        rst = $urandom_range(0, 299) == 0;
        step();
      end
    end
    rst = 0; pipe(0, 0, 0); late(0, 0, 0);
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
